// File: rtl/fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_pkg : shared Gray/binary helpers and synchronizer depth limits
// Rev 1.0
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int GRAY_MAX_WIDTH  = 32;

  // Callers zero-extend into GRAY_MAX_WIDTH and cast the result back down;
  // leading zeros leave both conversions unchanged in the low bits.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b = g;
    for (int i = 1; i < GRAY_MAX_WIDTH; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ndff.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_ndff : STAGES-deep multi-flop synchronizer, async active-low reset
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_ndff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             r_clk_i,
  input  logic             r_rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_q [STAGES];

  always_ff @(posedge r_clk_i or negedge r_rst_i) begin
    if (!r_rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        r_q[i] <= r_q[i-1];
      end
    end
  end

  assign q_o = r_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/gray_ptr_sync_rd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gray_ptr_sync_rd : async-FIFO read-side pointer logic (sync, empty, level).
// Optional Gray-step checker enabled by macro GRAY_PTR_SYNC_CHECK_EN. Rev 1.0
// ---------------------------------------------------------------------------
module gray_ptr_sync_rd
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 r_clk_i,
  input  logic                 r_rst_i,
  input  logic [PTR_WIDTH-1:0] w_ptr_gray_i,
  input  logic                 r_en_i,
  output logic [PTR_WIDTH-1:0] r_ptr_gray_o,
  output logic [PTR_WIDTH-2:0] r_addr_o,
  output logic                 r_empty_o,
  output logic [PTR_WIDTH-1:0] r_level_o,
  output logic [PTR_WIDTH-1:0] r_w_ptr_o,
  output logic                 r_err_o
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
    $error("gray_ptr_sync_rd: SYNC_STAGES must be within 2..4");
  end
  if (PTR_WIDTH < 2 || PTR_WIDTH > GRAY_MAX_WIDTH) begin : g_bad_ptr_width
    $error("gray_ptr_sync_rd: PTR_WIDTH must be within 2..32");
  end

  logic [PTR_WIDTH-1:0] w_wgs;
  logic [PTR_WIDTH-1:0] r_rb;
  logic [PTR_WIDTH-1:0] w_rb_next;
  logic [PTR_WIDTH-1:0] w_rb_next_gray;
  logic                 w_rd;

  sync_ndff #(
    .WIDTH  (PTR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .r_clk_i (r_clk_i),
    .r_rst_i (r_rst_i),
    .d_i     (w_ptr_gray_i),
    .q_o     (w_wgs)
  );

  assign r_w_ptr_o      = PTR_WIDTH'(gray2bin(GRAY_MAX_WIDTH'(w_wgs)));
  assign w_rd           = r_en_i && !r_empty_o;
  assign w_rb_next      = r_rb + {{(PTR_WIDTH-1){1'b0}}, w_rd};
  assign w_rb_next_gray = PTR_WIDTH'(bin2gray(GRAY_MAX_WIDTH'(w_rb_next)));
  assign r_addr_o       = r_rb[PTR_WIDTH-2:0];

  // Flags are computed from the next read pointer so a read and a write step
  // landing on the same edge are both reflected in one update.
  always_ff @(posedge r_clk_i or negedge r_rst_i) begin
    if (!r_rst_i) begin
      r_rb         <= '0;
      r_ptr_gray_o <= '0;
      r_empty_o    <= 1'b1;
      r_level_o    <= '0;
    end else begin
      r_rb         <= w_rb_next;
      r_ptr_gray_o <= w_rb_next_gray;
      r_empty_o    <= (w_rb_next_gray == w_wgs);
      r_level_o    <= r_w_ptr_o - w_rb_next;
    end
  end

`ifdef GRAY_PTR_SYNC_CHECK_EN
  logic [PTR_WIDTH-1:0] r_wgs_prev;
  logic                 r_err;

  always_ff @(posedge r_clk_i or negedge r_rst_i) begin
    if (!r_rst_i) begin
      r_wgs_prev <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wgs_prev <= w_wgs;
      if ($countones(r_wgs_prev ^ w_wgs) > 1) begin
        r_err <= 1'b1;
      end
    end
  end

  assign r_err_o = r_err;
`else
  assign r_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_ptr_sync_rd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gray_ptr_sync_rd : directed bench for gray_ptr_sync_rd (PTR_WIDTH=4)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_gray_ptr_sync_rd;

  localparam int PW = 4;
  localparam int SS = 2;

  logic          clk;
  logic          rst_n;
  logic [PW-1:0] w_gray;
  logic          r_en;
  logic [PW-1:0] ptr_gray;
  logic [PW-2:0] addr;
  logic          empty;
  logic [PW-1:0] level;
  logic [PW-1:0] w_ptr;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [PW-1:0] wb;
  logic [PW-1:0] exp_rb;
  logic          exp_err;

  gray_ptr_sync_rd #(
    .PTR_WIDTH   (PW),
    .SYNC_STAGES (SS)
  ) dut (
    .r_clk_i      (clk),
    .r_rst_i      (rst_n),
    .w_ptr_gray_i (w_gray),
    .r_en_i       (r_en),
    .r_ptr_gray_o (ptr_gray),
    .r_addr_o     (addr),
    .r_empty_o    (empty),
    .r_level_o    (level),
    .r_w_ptr_o    (w_ptr),
    .r_err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_wb(input logic [PW-1:0] v);
    wb     = v;
    w_gray = v ^ (v >> 1);
  endtask

  initial begin
`ifdef GRAY_PTR_SYNC_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_n = 1'b0;
    r_en  = 1'b0;
    set_wb(4'd0);
    #12;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_gray",  32'(ptr_gray), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    r_en = 1'b1;
    step(1);
    check("rst_ignores_ren", 32'(addr), 32'd0);
    rst_n = 1'b1;

    // Underflow: reads while empty must be ignored
    step(10);
    check("uflow_addr",  32'(addr), 32'd0);
    check("uflow_level", 32'(level), 32'd0);
    check("uflow_empty", 32'(empty), 32'd1);
    r_en = 1'b0;

    // Single write: visible on r_w_ptr_o after 2 edges, flags after 3
    set_wb(4'd1);
    step(1);
    check("sw_e1_wptr", 32'(w_ptr), 32'd0);
    step(1);
    check("sw_e2_wptr",  32'(w_ptr), 32'd1);
    check("sw_e2_empty", 32'(empty), 32'd1);
    step(1);
    check("sw_e3_empty", 32'(empty), 32'd0);
    check("sw_e3_level", 32'(level), 32'd1);
    r_en = 1'b1;
    step(1);
    r_en = 1'b0;
    check("sw_rd_addr",  32'(addr), 32'd1);
    check("sw_rd_gray",  32'(ptr_gray), 32'd1);
    check("sw_rd_empty", 32'(empty), 32'd1);
    check("sw_rd_level", 32'(level), 32'd0);

    // Full level: 8 writes, no reads (rb=1, wb 1 -> 9)
    for (int i = 0; i < 8; i++) begin
      set_wb(wb + 4'd1);
      step(1);
    end
    step(SS + 1);
    check("full_level", 32'(level), 32'd8);
    check("full_empty", 32'(empty), 32'd0);
    r_en = 1'b1;
    step(7);
    check("drain7_level", 32'(level), 32'd1);
    check("drain7_empty", 32'(empty), 32'd0);
    step(1);
    check("drain8_level", 32'(level), 32'd0);
    check("drain8_empty", 32'(empty), 32'd1);
    check("drain8_addr",  32'(addr), 32'd1);
    step(2);
    check("drain_hold_addr", 32'(addr), 32'd1);
    r_en = 1'b0;

    // Wrap: 20 interleaved write/read pairs starting at rb=9
    exp_rb = 4'd9;
    for (int i = 0; i < 20; i++) begin
      set_wb(wb + 4'd1);
      step(SS + 1);
      check("wrap_wptr",  32'(w_ptr), 32'(wb));
      check("wrap_level", 32'(level), 32'd1);
      r_en = 1'b1;
      step(1);
      r_en = 1'b0;
      exp_rb = exp_rb + 4'd1;
      check("wrap_gray",  32'(ptr_gray), 32'(exp_rb ^ (exp_rb >> 1)));
      check("wrap_addr",  32'(addr), 32'(exp_rb[PW-2:0]));
      check("wrap_empty", 32'(empty), 32'd1);
      if (exp_rb == 4'd15) check("wrap_gray15", 32'(ptr_gray), 32'b1000);
      if (exp_rb == 4'd0)  check("wrap_gray0",  32'(ptr_gray), 32'b0000);
    end

    // Reset mid-traffic with pointer steps still in the synchronizer
    set_wb(wb + 4'd1);
    step(1);
    set_wb(wb + 4'd1);
    r_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_gray",  32'(ptr_gray), 32'd0);
    check("mid_rst_err",   32'(err), 32'd0);
    check("mid_rst_wptr",  32'(w_ptr), 32'd0);
    set_wb(4'd0);
    r_en = 1'b0;
    step(1);
    #3;
    rst_n = 1'b1;
    step(SS + 2);
    check("post_rst_wptr",  32'(w_ptr), 32'd0);
    check("post_rst_empty", 32'(empty), 32'd1);

    // Gray violation: 0 -> 3 flips two bits at once
    w_gray = 4'b0011;
    step(SS);
    check("gv_e2_err", 32'(err), 32'd0);
    step(1);
    check("gv_e3_err", 32'(err), 32'(exp_err));
    w_gray = 4'b0010;
    step(6);
    check("gv_sticky_err", 32'(err), 32'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_ptr_sync_rd.md
GRAY_PTR_SYNC_RD -- requirements
Module: gray_ptr_sync_rd

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 8: pointer width including the wrap bit; FIFO depth = 2**(PTR_WIDTH-1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop count; legal range 2..4.
REQ-003 SHALL have port r_clk_i, input, 1: read-domain clock.
REQ-004 SHALL have port r_rst_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port w_ptr_gray_i, input, PTR_WIDTH: Gray-coded write pointer, launched from a flop in the write domain.
REQ-006 SHALL have port r_en_i, input, 1: read request.
REQ-007 SHALL have port r_ptr_gray_o, output, PTR_WIDTH: registered Gray read pointer for the write-domain synchronizer.
REQ-008 SHALL have port r_addr_o, output, PTR_WIDTH-1: RAM read address, equal to the lower bits of the binary read pointer.
REQ-009 SHALL have port r_empty_o, output, 1: FIFO empty, registered.
REQ-010 SHALL have port r_level_o, output, PTR_WIDTH: fill level as seen by the read domain, registered.
REQ-011 SHALL have port r_w_ptr_o, output, PTR_WIDTH: synchronized write pointer, converted to binary.
REQ-012 SHALL have port r_err_o, output, 1: sticky Gray-violation flag (see Configuration).

Function
REQ-013 SHALL pass w_ptr_gray_i through a chain of SYNC_STAGES flops; the last stage is the synchronized Gray pointer wgs.
REQ-014 SHALL make wgs equal w_ptr_gray_i as sampled SYNC_STAGES r_clk_i edges earlier.
REQ-015 SHALL drive r_w_ptr_o = gray2bin(wgs), combinational from the last stage.
REQ-016 SHALL hold the binary read pointer rb and define rb_next = rb + 1 when (r_en_i && !r_empty_o), else rb_next = rb.
REQ-017 SHALL ignore r_en_i while r_empty_o = 1: no pointer change and no underflow.
REQ-018 SHALL compute rb + 1 modulo 2**PTR_WIDTH, so all-ones wraps to 0.
REQ-019 SHALL register rb <= rb_next and r_ptr_gray_o <= rb_next ^ (rb_next >> 1) on each edge.
REQ-020 SHALL register r_empty_o <= (bin2gray(rb_next) == wgs) on each edge.
REQ-021 SHALL register r_level_o <= (gray2bin(wgs) - rb_next) modulo 2**PTR_WIDTH on each edge.
REQ-022 SHALL give r_level_o a range of 0..2**(PTR_WIDTH-1).
REQ-023 SHALL evaluate a read and a write-pointer change arriving on the same edge together, so r_level_o reflects both.
REQ-024 SHALL make the latency from a write-pointer step to r_empty_o deassertion exactly SYNC_STAGES+1 edges.
REQ-025 SHALL ensure no combinational path exists from w_ptr_gray_i to any output.

Reset
REQ-026 SHALL, on r_rst_i low, asynchronously clear all sync stages, rb, r_ptr_gray_o, r_level_o and r_err_o to 0, and set r_empty_o to 1.
REQ-027 SHALL ignore r_en_i during reset; outputs hold reset values until the first edge after r_rst_i rises.
REQ-028 SHALL, on reset mid-operation, discard in-flight synchronizer contents.

Configuration
REQ-029 SHALL use macro GRAY_PTR_SYNC_CHECK_EN to enable the Gray checker.
REQ-030 SHALL, when GRAY_PTR_SYNC_CHECK_EN is defined, register the previous wgs and set r_err_o when consecutive wgs values differ in more than one bit.
REQ-031 SHALL keep r_err_o set until reset.
REQ-032 SHALL assert r_err_o one edge after the offending wgs value appears, i.e. SYNC_STAGES+1 edges after the input event.
REQ-033 SHALL, when GRAY_PTR_SYNC_CHECK_EN is undefined, tie r_err_o to constant 0 and add no checker flops.

Structure
REQ-034 SHALL place functions gray2bin and bin2gray (PTR_WIDTH-generic) and the SYNC_STAGES legal-range constants in shared package fifo_pkg.
REQ-035 SHALL implement the flop chain as sub-module sync_ndff (parameters WIDTH and STAGES; async active-low reset), reusable by the write-side counterpart.
REQ-036 SHALL trap SYNC_STAGES outside 2..4 at elaboration.

Verification
REQ-037 SHALL verify reset: assert r_rst_i low mid-traffic -> immediately r_empty_o=1, r_level_o=0, r_ptr_gray_o=0, r_err_o=0.
REQ-038 SHALL verify single write: w_ptr_gray_i 0->1 (SYNC_STAGES=2) -> r_w_ptr_o=1 after edge 2; r_empty_o=0 and r_level_o=1 after edge 3.
REQ-039 SHALL verify underflow: hold r_en_i=1 while empty for 10 edges -> r_addr_o stays 0, r_level_o=0.
REQ-040 SHALL verify wrap: PTR_WIDTH=4, 20 writes/reads interleaved -> rb wraps 15->0, r_ptr_gray_o 4'b1000->4'b0000, r_empty_o=1 after draining.
REQ-041 SHALL verify full level: write 8 entries (PTR_WIDTH=4) with no reads -> r_level_o=8 and r_empty_o=0; read 8 -> r_level_o=0 and r_empty_o=1 one edge after the last read.
REQ-042 SHALL verify the checker with GRAY_PTR_SYNC_CHECK_EN: w_ptr_gray_i jumps 0->3 -> r_err_o=1 at edge SYNC_STAGES+1 and stays 1; without the macro, r_err_o stays 0.
